conv_encoder_k4: RTL and testbench

CONV_ENCODER_K4 -- requirements
Module: conv_encoder_k4

---
 rtl/viterbi_pkg.sv | 20 ++
 rtl/conv_enc_parity.sv | 16 +
 rtl/conv_encoder_k4.sv | 110 +++++++++++
 tb/tb_conv_encoder_k4.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Constants and types shared by the K=4 convolutional encoder and the Viterbi decoder.
package viterbi_pkg;

   localparam int unsigned K        = 4;
   localparam int unsigned TAIL_LEN = K - 1;
   localparam logic [K-1:0] G0_OCT  = 4'o17;
   localparam logic [K-1:0] G1_OCT  = 4'o15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_TAIL = 2'd2
   } enc_state_e;

   // Generator MSB taps the bit being encoded; lower bits tap progressively older history.
   function automatic logic gen_parity(input logic [K-1:0] g, input logic b, input logic [K-2:0] sr);
      return ^(g & {b, sr[0], sr[1], sr[2]});
   endfunction

endpackage

// File: rtl/conv_enc_parity.sv
// Combinational G0/G1 parity for one code symbol: pair_o[1]=G0, pair_o[0]=G1.
module conv_enc_parity
   import viterbi_pkg::*;
(
   input  logic       b_i,
   input  logic [2:0] sr_i,
   output logic [1:0] pair_o
);

   always_comb begin
      pair_o    = '0;
      pair_o[1] = gen_parity(G0_OCT, b_i, sr_i);
      pair_o[0] = gen_parity(G1_OCT, b_i, sr_i);
   end

endmodule

// File: rtl/conv_encoder_k4.sv
// Rate-1/2 K=4 convolutional encoder with valid/ready streaming, zero-tail flush and frame bit count.
module conv_encoder_k4
   import viterbi_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_bit,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_pair,
   output logic             out_last,
   output logic [CNT_W-1:0] frame_bits
);

   localparam logic [1:0] TAIL_LAST = 2'(TAIL_LEN - 1);

   enc_state_e       state_q, state_d;
   logic [2:0]       sr_q, sr_d;
   logic [1:0]       tail_cnt_q, tail_cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [1:0]       out_pair_q, out_pair_d;
   logic             out_last_q, out_last_d;
   logic [CNT_W-1:0] frame_bits_q, frame_bits_d;

   logic       can_load;
   logic       in_xfer;
   logic       enc_bit;
   logic [1:0] pair;

   // Tail symbols always encode a zero; otherwise the incoming bit is encoded.
   assign enc_bit  = (state_q == ST_TAIL) ? 1'b0 : in_bit;
   assign can_load = !out_valid_q || out_ready;
   assign in_ready = !rst && (state_q != ST_TAIL) && can_load;
   assign in_xfer  = in_valid && in_ready;

   conv_enc_parity u_parity (
      .b_i    (enc_bit),
      .sr_i   (sr_q),
      .pair_o (pair)
   );

   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      tail_cnt_d   = tail_cnt_q;
      out_valid_d  = out_valid_q;
      out_pair_d   = out_pair_q;
      out_last_d   = out_last_q;
      frame_bits_d = frame_bits_q;

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (in_xfer) begin
         out_valid_d = 1'b1;
         out_pair_d  = pair;
         out_last_d  = 1'b0;
         sr_d        = {sr_q[1:0], in_bit};
         state_d     = in_last ? ST_TAIL : ST_RUN;
         if (state_q == ST_IDLE) begin
            frame_bits_d = CNT_W'(1);
         end else if (frame_bits_q != '1) begin
            frame_bits_d = frame_bits_q + CNT_W'(1);
         end
      end else if ((state_q == ST_TAIL) && can_load) begin
         out_valid_d = 1'b1;
         out_pair_d  = pair;
         if (tail_cnt_q == TAIL_LAST) begin
            out_last_d = 1'b1;
            tail_cnt_d = '0;
            sr_d       = '0;
            state_d    = ST_IDLE;
         end else begin
            out_last_d = 1'b0;
            tail_cnt_d = tail_cnt_q + 2'd1;
            sr_d       = {sr_q[1:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sr_q         <= '0;
         tail_cnt_q   <= '0;
         out_valid_q  <= 1'b0;
         out_pair_q   <= '0;
         out_last_q   <= 1'b0;
         frame_bits_q <= '0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         tail_cnt_q   <= tail_cnt_d;
         out_valid_q  <= out_valid_d;
         out_pair_q   <= out_pair_d;
         out_last_q   <= out_last_d;
         frame_bits_q <= frame_bits_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_pair   = out_pair_q;
   assign out_last   = out_last_q;
   assign frame_bits = frame_bits_q;

endmodule

// File: tb/tb_conv_encoder_k4.sv
// Self-checking bench for conv_encoder_k4: hand sequences, a frame table and random frames vs a tap model.
module tb_conv_encoder_k4;

   localparam logic [3:0] TB_G0 = 4'o17;
   localparam logic [3:0] TB_G1 = 4'o15;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_bit, in_last, out_ready;
   logic        in_ready, out_valid, out_last;
   logic [1:0]  out_pair;
   logic [15:0] frame_bits;
   logic        in_ready4, out_valid4, out_last4;
   logic [1:0]  out_pair4;
   logic [3:0]  frame_bits4;

   always #5 clk = ~clk;

   conv_encoder_k4 #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_pair(out_pair),
      .out_last(out_last), .frame_bits(frame_bits)
   );

   conv_encoder_k4 #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_bit(in_bit),
      .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready), .out_pair(out_pair4),
      .out_last(out_last4), .frame_bits(frame_bits4)
   );

   typedef struct packed {
      logic [1:0] pair;
      logic       last;
   } sym_t;

   typedef struct {
      int          len;
      logic [31:0] bits;
      int          mode;
      bit          drain;
   } frame_vec_t;

   sym_t exp_q[$];
   sym_t mon_e;
   int   passed = 0;
   int   total = 0;
   int   rx_count = 0;
   int   mode = 0;
   bit   tog = 1'b0;
   bit   mon_en = 1'b0;
   bit   stalled_prev = 1'b0;
   logic [1:0] prev_pair;
   logic       prev_last;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Output-side monitor: scoreboard on every transfer, stall stability, backpressure on in_ready.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         check("cnt4_out_valid", {31'd0, out_valid4}, {31'd0, out_valid});
         check("cnt4_in_ready", {31'd0, in_ready4}, {31'd0, in_ready});
         if (stalled_prev) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_pair", {30'd0, out_pair}, {30'd0, prev_pair});
            check("stall_last", {31'd0, out_last}, {31'd0, prev_last});
         end
         if (out_valid && !out_ready) check("in_ready_stall", {31'd0, in_ready}, 32'd0);
         if (out_valid && out_ready) begin
            rx_count++;
            check("symbol_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("out_pair", {30'd0, out_pair}, {30'd0, mon_e.pair});
               check("out_last", {31'd0, out_last}, {31'd0, mon_e.last});
               check("cnt4_out_pair", {30'd0, out_pair4}, {30'd0, out_pair});
            end
         end
      end
      stalled_prev = mon_en && !rst && out_valid && !out_ready;
      prev_pair    = out_pair;
      prev_last    = out_last;
   end

   task automatic cycle();
      @(posedge clk);
      #1;
      case (mode)
         0:       out_ready = 1'b1;
         1:       begin tog = ~tog; out_ready = tog; end
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   // Reference: each symbol is a tap-weighted XOR over the zero-padded information sequence.
   task automatic push_model(input int len, input logic [31:0] bits);
      sym_t s;
      logic [3:0] g0, g1;
      logic u;
      g0 = TB_G0;
      g1 = TB_G1;
      for (int i = 0; i < len + 3; i++) begin
         s = '0;
         for (int d = 0; d < 4; d++) begin
            u = (i - d >= 0 && i - d < len) ? bits[i - d] : 1'b0;
            if (g0[3 - d]) s.pair[1] = s.pair[1] ^ u;
            if (g1[3 - d]) s.pair[0] = s.pair[0] ^ u;
         end
         s.last = (i == len + 2);
         exp_q.push_back(s);
      end
   endtask

   task automatic send_frame(input int len, input logic [31:0] bits);
      bit acc;
      int guard;
      for (int i = 0; i < len; i++) begin
         in_valid = 1'b1;
         in_bit   = bits[i];
         in_last  = (i == len - 1);
         acc      = 1'b0;
         guard    = 0;
         while (!acc && guard < 100) begin
            #3;
            acc = in_ready;
            cycle();
            guard++;
         end
         check("in_accept", {31'd0, acc}, 32'd1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 500) begin
         cycle();
         guard++;
      end
      check("drain_empty", exp_q.size(), 32'd0);
   endtask

   task automatic push_impulse();
      exp_q.push_back('{pair: 2'b11, last: 1'b0});
      exp_q.push_back('{pair: 2'b11, last: 1'b0});
      exp_q.push_back('{pair: 2'b10, last: 1'b0});
      exp_q.push_back('{pair: 2'b11, last: 1'b1});
   endtask

   frame_vec_t vecs[6];
   int sym_exp;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{len: 8,  bits: 32'h0,        mode: 0, drain: 1'b1};
      vecs[1] = '{len: 4,  bits: 32'hD,        mode: 0, drain: 1'b0};
      vecs[2] = '{len: 2,  bits: 32'h2,        mode: 0, drain: 1'b1};
      vecs[3] = '{len: 20, bits: 32'hA5A5F,    mode: 2, drain: 1'b1};
      vecs[4] = '{len: 32, bits: 32'hDEADBEEF, mode: 2, drain: 1'b1};
      vecs[5] = '{len: 5,  bits: 32'h15,       mode: 1, drain: 1'b1};

      rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      mode = 0;
      cycle();
      cycle();
      #3;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_pair", {30'd0, out_pair}, 32'd0);
      check("rst_out_last", {31'd0, out_last}, 32'd0);
      check("rst_frame_bits", {16'd0, frame_bits}, 32'd0);
      cycle();
      rst = 1'b0;
      mon_en = 1'b1;

      // Impulse, free-flowing output.
      rx_count = 0;
      push_impulse();
      send_frame(1, 32'h1);
      drain();
      check("impulse_syms", rx_count, 32'd4);
      check("impulse_frame_bits", {16'd0, frame_bits}, 32'd1);

      // Impulse under alternating backpressure.
      mode = 1; tog = 1'b0;
      rx_count = 0;
      push_impulse();
      send_frame(1, 32'h1);
      drain();
      check("bp_impulse_syms", rx_count, 32'd4);
      check("bp_frame_bits", {16'd0, frame_bits}, 32'd1);

      // Table: zero frame, back-to-back pair, saturation frame, long and toggled frames.
      rx_count = 0;
      sym_exp  = 0;
      for (int v = 0; v < 6; v++) begin
         mode = vecs[v].mode;
         push_model(vecs[v].len, vecs[v].bits);
         sym_exp += vecs[v].len + 3;
         send_frame(vecs[v].len, vecs[v].bits);
         if (vecs[v].drain) begin
            drain();
            check("table_syms", rx_count, sym_exp);
            check("table_frame_bits", {16'd0, frame_bits}, vecs[v].len);
            check("table_frame_bits_cnt4", {28'd0, frame_bits4},
                  (vecs[v].len > 15) ? 32'd15 : vecs[v].len);
         end
      end

      // Random frames.
      for (int r = 0; r < 6; r++) begin
         int          len;
         logic [31:0] bits;
         len  = int'($urandom_range(1, 24));
         bits = $urandom;
         mode = 2;
         push_model(len, bits);
         send_frame(len, bits);
         drain();
         check("rand_frame_bits", {16'd0, frame_bits}, len);
      end

      // Reset pulsed during the tail abandons the frame.
      mode = 0;
      push_impulse();
      send_frame(1, 32'h1);
      cycle();
      mon_en = 1'b0;
      rst = 1'b1;
      #3;
      check("midtail_rst_in_ready", {31'd0, in_ready}, 32'd0);
      cycle();
      #3;
      check("midtail_out_valid", {31'd0, out_valid}, 32'd0);
      check("midtail_out_last", {31'd0, out_last}, 32'd0);
      check("midtail_frame_bits", {16'd0, frame_bits}, 32'd0);
      rst = 1'b0;
      exp_q.delete();
      cycle();
      mon_en = 1'b1;
      rx_count = 0;
      push_impulse();
      send_frame(1, 32'h1);
      drain();
      check("post_rst_syms", rx_count, 32'd4);
      check("post_rst_frame_bits", {16'd0, frame_bits}, 32'd1);

      cycle();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
